// File: rtl/data_sram_responder_pkg.sv
// Shared definitions for the data-memory responder: access sizes, FSM states and
// byte-lane helpers.
package data_sram_responder_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  // Size 3 is reserved and behaves as a word access.
  function automatic logic [3:0] be_of(logic [1:0] size, logic [1:0] lane);
    case (size)
      SIZE_BYTE: be_of = 4'b0001 << lane;
      SIZE_HALF: be_of = lane[1] ? 4'b1100 : 4'b0011;
      default:   be_of = 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(logic [1:0] size, logic [1:0] lane);
    case (size)
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = lane[0];
      default:   misaligned = (lane != 2'b00);
    endcase
  endfunction

  function automatic logic [31:0] replicate(logic [1:0] size, logic [31:0] data);
    case (size)
      SIZE_BYTE: replicate = {4{data[7:0]}};
      SIZE_HALF: replicate = {2{data[15:0]}};
      default:   replicate = data;
    endcase
  endfunction

endpackage

// File: rtl/data_sram_responder_sram_byte_array.sv
// Word-wide storage with per-byte write enables and a registered read port.
module sram_byte_array #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [IDX_W-1:0] idx,
  input  logic [3:0]       we,
  input  logic [31:0]      wdata,
  input  logic             re,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/data_sram_responder.sv
// CPU data-memory responder: one outstanding request, fixed wait states, then a
// single-cycle completion with a commit-time store strobe.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        err,
  output logic        memwrite,
  output logic [31:0] dataadr,
  output logic [31:0] writedata
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic        accept;
  logic        mis;
  logic        load_next;
  logic [IdxW-1:0] idx;
  logic [3:0]  we;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      StIdle: begin
        if (req) begin
          accept  = 1'b1;
          cnt_d   = 4'(LATENCY);
          state_d = (LATENCY == 0) ? StResp : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      size_q  <= SIZE_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wr_q    <= wr;
        size_q  <= size;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
    end
  end

  assign addr_ok   = (state_q == StIdle);
  assign data_ok   = (state_q == StResp);
  assign mis       = misaligned(size_q, addr_q[1:0]);
  assign err       = data_ok & mis;
  assign memwrite  = data_ok & wr_q & ~mis;
  assign dataadr   = addr_q;
  assign writedata = wdata_q;

  // With zero latency the read edge is the acceptance edge, so take the live request.
  assign load_next = (state_d == StResp) & ~(accept ? wr : wr_q);
  assign idx       = accept ? addr[2 +: IdxW] : addr_q[2 +: IdxW];
  assign we        = memwrite ? be_of(size_q, addr_q[1:0]) : 4'b0000;

  sram_byte_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IdxW)
  ) u_sram (
    .clk   (clk),
    .resetn(resetn),
    .idx   (idx),
    .we    (we),
    .wdata (replicate(size_q, wdata_q)),
    .re    (load_next),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: a LATENCY=2 instance for most scenarios and
// a LATENCY=0 instance for back-to-back throughput.
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req = 1'b0, wr = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [31:0] addr = '0, wdata = '0;
  logic        addr_ok, data_ok, err, memwrite;
  logic [31:0] rdata, dataadr, writedata;

  logic        req0 = 1'b0, wr0 = 1'b0;
  logic [1:0]  size0 = 2'd2;
  logic [31:0] addr0 = '0, wdata0 = '0;
  logic        addr_ok0, data_ok0, err0, memwrite0;
  logic [31:0] rdata0, dataadr0, writedata0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_sram_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .addr(addr),
    .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .err(err),
    .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata)
  );

  data_sram_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut0 (
    .clk(clk), .resetn(resetn), .req(req0), .wr(wr0), .size(size0), .addr(addr0),
    .wdata(wdata0), .addr_ok(addr_ok0), .data_ok(data_ok0), .rdata(rdata0), .err(err0),
    .memwrite(memwrite0), .dataadr(dataadr0), .writedata(writedata0)
  );

  // Issue one request to the LATENCY=2 instance and capture what happens at data_ok.
  task automatic issue(input logic w, input logic [1:0] s, input logic [31:0] a,
                       input logic [31:0] d, output int lat, output int lo_cnt,
                       output logic [31:0] rd, output logic e, output logic mw,
                       output logic [31:0] da, output logic [31:0] wd);
    lat = -1; lo_cnt = 0; rd = '0; e = 1'b0; mw = 1'b0; da = '0; wd = '0;
    @(negedge clk);
    req = 1'b1; wr = w; size = s; addr = a; wdata = d;
    @(posedge clk);
    #1 req = 1'b0; wr = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'hFFFF_FFFF;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (data_ok && lat < 0) begin
        lat = i; rd = rdata; e = err; mw = memwrite; da = dataadr; wd = writedata;
      end
      if (!addr_ok) lo_cnt++;
      else break;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (addr_ok !== 1'b1 || data_ok !== 1'b0 || err !== 1'b0 || memwrite !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got addr_ok=%b data_ok=%b err=%b memwrite=%b, want 1 0 0 0",
               addr_ok, data_ok, err, memwrite);
    end
    checks++;
    if (rdata !== 32'h0 || dataadr !== 32'h0 || writedata !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got rdata=%h dataadr=%h writedata=%h, want zeros",
               rdata, dataadr, writedata);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_store_word();
    int lat, lo; logic [31:0] rd, da, wd; logic e, mw;
    issue(1'b1, 2'd2, 32'h54, 32'h7, lat, lo, rd, e, mw, da, wd);
    checks++;
    if (lat !== 3 || lo !== 3) begin
      errors++;
      $display("FAIL store_word_timing: got latency=%0d addr_ok_low=%0d, want 3 3", lat, lo);
    end
    checks++;
    if (mw !== 1'b1 || da !== 32'h54 || wd !== 32'h7 || e !== 1'b0) begin
      errors++;
      $display("FAIL store_word_strobe: got mw=%b da=%h wd=%h err=%b, want 1 54 7 0",
               mw, da, wd, e);
    end
  endtask

  task automatic test_load_word();
    int lat, lo; logic [31:0] rd, da, wd; logic e, mw;
    issue(1'b0, 2'd2, 32'h54, 32'h0, lat, lo, rd, e, mw, da, wd);
    checks++;
    if (lat !== 3 || rd !== 32'h7 || e !== 1'b0 || mw !== 1'b0) begin
      errors++;
      $display("FAIL load_word: got lat=%0d rdata=%h err=%b mw=%b, want 3 00000007 0 0",
               lat, rd, e, mw);
    end
    checks++;
    if (rdata !== 32'h7) begin
      errors++;
      $display("FAIL rdata_hold: got %h after data_ok, want 00000007", rdata);
    end
  endtask

  task automatic test_sub_word();
    int lat, lo; logic [31:0] rd, da, wd; logic e, mw;
    issue(1'b1, 2'd2, 32'h50, 32'h1122_3344, lat, lo, rd, e, mw, da, wd);
    issue(1'b1, 2'd0, 32'h51, 32'h0000_00AB, lat, lo, rd, e, mw, da, wd);
    checks++;
    if (mw !== 1'b1 || wd !== 32'hAB || da !== 32'h51) begin
      errors++;
      $display("FAIL store_byte_strobe: got mw=%b da=%h wd=%h, want 1 51 000000ab", mw, da, wd);
    end
    issue(1'b0, 2'd2, 32'h50, 32'h0, lat, lo, rd, e, mw, da, wd);
    checks++;
    if (rd !== 32'h1122_AB44) begin
      errors++;
      $display("FAIL store_byte_merge: got %h, want 1122ab44", rd);
    end
    issue(1'b1, 2'd1, 32'h52, 32'h0000_5678, lat, lo, rd, e, mw, da, wd);
    issue(1'b0, 2'd2, 32'h50, 32'h0, lat, lo, rd, e, mw, da, wd);
    checks++;
    if (rd !== 32'h5678_AB44) begin
      errors++;
      $display("FAIL store_half_merge: got %h, want 5678ab44", rd);
    end
  endtask

  task automatic test_misaligned();
    int lat, lo; logic [31:0] rd, da, wd; logic e, mw;
    issue(1'b1, 2'd1, 32'h53, 32'h0000_1234, lat, lo, rd, e, mw, da, wd);
    checks++;
    if (lat !== 3 || e !== 1'b1 || mw !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_store: got lat=%0d err=%b mw=%b, want 3 1 0", lat, e, mw);
    end
    issue(1'b0, 2'd2, 32'h50, 32'h0, lat, lo, rd, e, mw, da, wd);
    checks++;
    if (rd !== 32'h5678_AB44 || e !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_no_write: got %h err=%b, want 5678ab44 0", rd, e);
    end
    issue(1'b0, 2'd2, 32'h52, 32'h0, lat, lo, rd, e, mw, da, wd);
    checks++;
    if (rd !== 32'h5678_AB44 || e !== 1'b1) begin
      errors++;
      $display("FAIL misaligned_load: got %h err=%b, want 5678ab44 1", rd, e);
    end
    issue(1'b1, 2'd3, 32'h4C, 32'h0000_0001, lat, lo, rd, e, mw, da, wd);
    checks++;
    if (e !== 1'b0 || mw !== 1'b1) begin
      errors++;
      $display("FAIL size3_as_word: got err=%b mw=%b, want 0 1", e, mw);
    end
  endtask

  task automatic test_alias();
    int lat, lo; logic [31:0] rd, da, wd; logic e, mw;
    issue(1'b0, 2'd2, 32'h454, 32'h0, lat, lo, rd, e, mw, da, wd);
    checks++;
    if (rd !== 32'h7) begin
      errors++;
      $display("FAIL alias_load: got %h, want 00000007", rd);
    end
    issue(1'b1, 2'd2, 32'h458, 32'h0BAD_F00D, lat, lo, rd, e, mw, da, wd);
    issue(1'b0, 2'd2, 32'h58, 32'h0, lat, lo, rd, e, mw, da, wd);
    checks++;
    if (rd !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL alias_store: got %h, want 0badf00d", rd);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req0 = 1'b1; wr0 = 1'b1; size0 = 2'd2; addr0 = 32'h10; wdata0 = 32'hCAFE_F00D;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (addr_ok0 !== (k % 2 == 0) || data_ok0 !== (k % 2 == 1)
          || memwrite0 !== (k % 2 == 1)) begin
        errors++;
        $display("FAIL b2b_cycle%0d: got addr_ok=%b data_ok=%b memwrite=%b, want %b %b %b",
                 k, addr_ok0, data_ok0, memwrite0, k % 2 == 0, k % 2 == 1, k % 2 == 1);
      end
    end
    wr0 = 1'b0; addr0 = 32'h10;
    @(posedge clk);
    #1 req0 = 1'b0;
    @(negedge clk);
    checks++;
    if (data_ok0 !== 1'b1 || rdata0 !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL lat0_load: got data_ok=%b rdata=%h, want 1 cafef00d", data_ok0, rdata0);
    end
  endtask

  task automatic test_reset_in_wait();
    int lat, lo; logic [31:0] rd, da, wd; logic e, mw;
    logic seen;
    issue(1'b1, 2'd2, 32'h60, 32'h5A5A_5A5A, lat, lo, rd, e, mw, da, wd);
    @(negedge clk);
    req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h60; wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 req = 1'b0; wr = 1'b0;
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (addr_ok !== 1'b1 || dataadr !== 32'h0) begin
      errors++;
      $display("FAIL reset_in_wait: got addr_ok=%b dataadr=%h, want 1 00000000",
               addr_ok, dataadr);
    end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (data_ok || memwrite) seen = 1'b1;
    end
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (data_ok || memwrite) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL dropped_pulse: got data_ok/memwrite pulse=%b, want 0", seen);
    end
    issue(1'b0, 2'd2, 32'h60, 32'h0, lat, lo, rd, e, mw, da, wd);
    checks++;
    if (rd !== 32'h5A5A_5A5A) begin
      errors++;
      $display("FAIL dropped_store: got %h, want 5a5a5a5a", rd);
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_word();
    test_sub_word();
    test_misaligned();
    test_alias();
    test_back_to_back();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
